// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and receiver state encoding for the UART path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_sync.sv
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchronizer for asynchronous inputs, resets high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Reset high so an idle-high line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver on a 16x oversampling enable, with a
//               one-entry valid/ready holding register and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] c_mid_tick  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] c_last_tick = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t             state_q,     state_d;
    logic [TICK_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q,     shift_d;
    logic [DATA_BITS-1:0]  rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    logic                  w_stop_ok;
    logic                  w_stop_bad;

    rx_sync u_rx_sync (
        .clk     (CLK100MHZ),
        .rst     (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;

        if (tick_16x) begin
            case (state_q)
                IDLE: begin
                    if (!w_rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == c_mid_tick) begin
                        if (!w_rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == c_last_tick) begin
                        tick_cnt_d = '0;
                        shift_d    = {w_rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == c_last_bit) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == c_last_tick) begin
                        tick_cnt_d = '0;
                        if (w_rx_s) begin
                            w_stop_ok = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            w_stop_bad = 1'b1;
                            state_d    = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                BREAK: begin
                    // Wait for the line to recover so a held-low line does not retrigger.
                    if (w_rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = w_stop_bad;
        overrun_d   = 1'b0;

        // A load wins over a concurrent accept; a full, unaccepted register drops the byte.
        if (w_stop_ok) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (tick every 4 clocks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT_CYC = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_rx dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .tick_16x  (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        if (rx_valid) begin
            valid_cycles <= valid_cycles + 1;
            last_data    <= rx_data;
        end
        if (rx_valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(4);
        tests++; if (rx_data !== 8'h00)  begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        tests++; if (rx_valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
        idle(8);
    endtask

    task automatic test_single_byte();
        int v0, f0, o0;
        rx_ready = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        idle(20);
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        tests++; if (last_data !== 8'hA5)     begin fails++; $display("FAIL single_data: got %h expected a5", last_data); end
        tests++; if (fe_cnt - f0 !== 0)       begin fails++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - f0); end
        tests++; if (ov_cnt - o0 !== 0)       begin fails++; $display("FAIL single_overrun: got %0d expected 0", ov_cnt - o0); end
        tests++; if (rx_valid !== 1'b0)       begin fails++; $display("FAIL single_valid_after: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'hA5)       begin fails++; $display("FAIL single_data_held: got %h expected a5", rx_data); end
    endtask

    task automatic test_glitch();
        int r0, f0;
        rx_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt;
        rx = 1'b0;
        idle(12);
        rx = 1'b1;
        idle(700);
        tests++; if (rise_cnt - r0 !== 0) begin fails++; $display("FAIL glitch_valid: got %0d expected 0", rise_cnt - r0); end
        tests++; if (fe_cnt - f0 !== 0)   begin fails++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - f0); end
    endtask

    task automatic test_framing_error();
        int v0, f0, o0, r0;
        rx_ready = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt; r0 = rise_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        idle(160);
        rx = 1'b1;
        idle(BIT_CYC);
        send_frame(8'h81, 1'b1);
        idle(20);
        tests++; if (fe_cnt - f0 !== 1)       begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - f0); end
        tests++; if (rise_cnt - r0 !== 1)     begin fails++; $display("FAIL ferr_deliveries: got %0d expected 1", rise_cnt - r0); end
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL ferr_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        tests++; if (last_data !== 8'h81)     begin fails++; $display("FAIL ferr_next_data: got %h expected 81", last_data); end
        tests++; if (ov_cnt - o0 !== 0)       begin fails++; $display("FAIL ferr_overrun: got %0d expected 0", ov_cnt - o0); end
    endtask

    task automatic test_overrun();
        int o0, r0;
        rx_ready = 1'b0;
        o0 = ov_cnt; r0 = rise_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        tests++; if (rx_data !== 8'h11)   begin fails++; $display("FAIL ovr_data: got %h expected 11", rx_data); end
        tests++; if (rx_valid !== 1'b1)   begin fails++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
        tests++; if (ov_cnt - o0 !== 1)   begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - o0); end
        tests++; if (rise_cnt - r0 !== 1) begin fails++; $display("FAIL ovr_deliveries: got %0d expected 1", rise_cnt - r0); end
        rx_ready = 1'b1;
        idle(1);
        tests++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_valid); end
        rx_ready = 1'b0;
        idle(4);
    endtask

    task automatic test_back_to_back_accept();
        int o0, r0, target;
        bit hit;
        rx_ready = 1'b0;
        o0 = ov_cnt; r0 = rise_cnt;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                // The second frame starts 640 clocks after the first with the same tick phase.
                hit = 1'b0;
                for (int i = 0; i < 2000 && !hit; i++) begin
                    idle(1);
                    if (rise_cnt != r0) hit = 1'b1;
                end
                tests++; if (!hit) begin fails++; $display("FAIL b2b_first_delivery: got timeout expected delivery"); end
                target = rise_cyc - 1 + 10 * BIT_CYC;
                hit = 1'b0;
                for (int i = 0; i < 2000 && !hit; i++) begin
                    idle(1);
                    if (cyc == target) hit = 1'b1;
                end
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
        join
        idle(4);
        tests++; if (rx_data !== 8'h22)   begin fails++; $display("FAIL b2b_data: got %h expected 22", rx_data); end
        tests++; if (rx_valid !== 1'b1)   begin fails++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        tests++; if (ov_cnt - o0 !== 0)   begin fails++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt - o0); end
        tests++; if (rise_cnt - r0 !== 1) begin fails++; $display("FAIL b2b_rises: got %0d expected 1", rise_cnt - r0); end
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        tests++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL b2b_drain: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int f0, o0, r0;
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        idle(4);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        idle(32);
        f0 = fe_cnt; o0 = ov_cnt;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        tests++; if (rx_valid !== 1'b0)  begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'h00)  begin fails++; $display("FAIL rst_mid_data: got %h expected 00", rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_mid_frame_err: got %b expected 0", frame_err); end
        tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
        idle(800);
        tests++; if (fe_cnt - f0 !== 0)  begin fails++; $display("FAIL rst_mid_late_ferr: got %0d expected 0", fe_cnt - f0); end
        tests++; if (ov_cnt - o0 !== 0)  begin fails++; $display("FAIL rst_mid_late_ovr: got %0d expected 0", ov_cnt - o0); end
        tests++; if (rx_valid !== 1'b0)  begin fails++; $display("FAIL rst_mid_late_valid: got %b expected 0", rx_valid); end
        rx_ready = 1'b1;
        r0 = rise_cnt;
        send_frame(8'h5A, 1'b1);
        idle(20);
        tests++; if (rise_cnt - r0 !== 1) begin fails++; $display("FAIL rst_next_deliveries: got %0d expected 1", rise_cnt - r0); end
        tests++; if (last_data !== 8'h5A) begin fails++; $display("FAIL rst_next_data: got %h expected 5a", last_data); end
        tests++; if (rx_data !== 8'h5A)   begin fails++; $display("FAIL rst_next_data_held: got %h expected 5a", rx_data); end
    endtask

    initial begin
        rx       = 1'b1;
        rx_ready = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_back_to_back_accept();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
